// File: rtl/cpu_loader_if.sv
// Byte-stream link from the host into the program loader.
// The host (master) drives data/valid; the loader (slave) returns ready.
interface cpu_loader_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/cpu_loader.sv
// Framed program loader for cpu_cpu: HDR LEN P[0..LEN-1] CSUM -> 256-bit code image.
// code updates one edge after CSUM is accepted; ready drops only during the one-cycle COMMIT.
module cpu_loader #(
  parameter int         cpu_code_sz  = 256,
  parameter int         cpu_load_max = cpu_code_sz / 8,
  parameter logic [7:0] cpu_load_hdr = 8'hA5
) (
  input  logic                   clk,
  input  logic                   reset,
  cpu_loader_if.slave            in_if,
  output logic [cpu_code_sz-1:0] code,
  output logic                   cpu_reset,
  output logic                   busy,
  output logic                   err
);

  localparam int         aw    = $clog2(cpu_code_sz);
  localparam logic [7:0] max_b = 8'(cpu_load_max);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    COMMIT
  } state_t;

  state_t                 state;
  logic [cpu_code_sz-1:0] shadow;
  logic [5:0]             len;
  logic [5:0]             cnt;
  logic [7:0]             sum;
  logic                   xfer;
  logic [aw-1:0]          bidx;

  assign in_if.ready = (state != COMMIT);
  assign xfer        = in_if.valid && in_if.ready;
  assign bidx        = aw'({cnt, 3'b000});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shadow    <= '0;
      code      <= '0;
      len       <= '0;
      cnt       <= '0;
      sum       <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer && in_if.data == cpu_load_hdr) begin
            state <= LEN;
            busy  <= 1'b1;
            err   <= 1'b0;
          end
        end

        LEN: begin
          if (xfer) begin
            if (in_if.data == 8'd0 || in_if.data > max_b) begin
              // Bad length leaves a running CPU running.
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              len       <= in_if.data[5:0];
              cnt       <= '0;
              sum       <= '0;
              shadow    <= '0;
              cpu_reset <= 1'b1;
              state     <= DATA;
            end
          end
        end

        DATA: begin
          if (xfer) begin
            shadow[bidx +: 8] <= in_if.data;
            sum               <= sum + in_if.data;
            cnt               <= cnt + 6'd1;
            if (cnt == len - 6'd1) begin
              state <= CSUM;
            end
          end
        end

        CSUM: begin
          if (xfer) begin
            if (in_if.data == sum) begin
              state <= COMMIT;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end

        COMMIT: begin
          code      <= shadow;
          cpu_reset <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
